// File: rtl/weight_wr_ctrl_pkg.sv
// Shared constants, FSM encoding and helpers for the weight-bank write path.
package weight_wr_ctrl_pkg;

  localparam int unsigned KERNEL_WIDTH   = 72;
  localparam int unsigned NUM_BANKS      = 4;
  localparam int unsigned ADDR_WIDTH     = 10;
  localparam int unsigned BYTES_PER_WORD = 9;
  localparam int unsigned BYTE_CNT_WIDTH = 4;
  localparam int unsigned BANK_WIDTH     = $clog2(NUM_BANKS);
  localparam int unsigned COUNT_WIDTH    = ADDR_WIDTH + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RECV  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // One-hot write strobe for a bank index.
  function automatic logic [NUM_BANKS-1:0] bank_onehot(input logic [BANK_WIDTH-1:0] bank);
    return NUM_BANKS'(1) << bank;
  endfunction

  // A load must cover 1..2^ADDR_WIDTH words per bank.
  function automatic logic count_legal(input logic [COUNT_WIDTH-1:0] n);
    return (n != '0) && (n <= COUNT_WIDTH'(1 << ADDR_WIDTH));
  endfunction

endpackage

// File: rtl/weight_byte_packer.sv
// Packs 9 consecutive bytes into one kernel word, first byte in the LSBs.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   accept       byte_in is consumed this cycle
//   clear        drop any partial word (wins over accept)
//   byte_in      incoming weight byte
//   word_full_c  this cycle's accept completes the word
//   word_c       word including this cycle's byte (valid with word_full_c)
module weight_byte_packer
  import weight_wr_ctrl_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    accept,
  input  logic                    clear,
  input  logic [7:0]              byte_in,
  output logic                    word_full_c,
  output logic [KERNEL_WIDTH-1:0] word_c
);

  logic [BYTE_CNT_WIDTH-1:0] byte_cnt;
  logic [KERNEL_WIDTH-1:0]   word_q;

  // Insert the byte at its slot so the full word is available in the accepting cycle.
  always_comb begin
    word_c = word_q;
    for (int k = 0; k < int'(BYTES_PER_WORD); k++) begin
      if (accept && (byte_cnt == BYTE_CNT_WIDTH'(k))) begin
        word_c[8*k +: 8] = byte_in;
      end
    end
  end

  assign word_full_c = accept && (byte_cnt == BYTE_CNT_WIDTH'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      byte_cnt <= '0;
      word_q   <= '0;
    end else if (accept) begin
      byte_cnt <= byte_cnt + 1'b1;
      word_q   <= word_c;
    end
  end

endmodule

// File: rtl/weight_wr_ctrl.sv
// Writer side of the weight-bank interface: packs the byte stream into kernel
// words and writes them round-robin across the banks at a shared address.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   i_start           start pulse (IDLE only), i_num_words sampled with it
//   i_abort           abandon the load, partial word discarded
//   i_byte_valid/i_byte, o_byte_ready   byte stream handshake
//   o_wr_en/o_wr_addr/o_wr_data          bank write port (one-hot strobe)
//   o_busy, o_done, o_err                load status
module weight_wr_ctrl
  import weight_wr_ctrl_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_start,
  input  logic [COUNT_WIDTH-1:0]  i_num_words,
  input  logic                    i_abort,
  input  logic                    i_byte_valid,
  input  logic [7:0]              i_byte,
  output logic                    o_byte_ready,
  output logic [NUM_BANKS-1:0]    o_wr_en,
  output logic [ADDR_WIDTH-1:0]   o_wr_addr,
  output logic [KERNEL_WIDTH-1:0] o_wr_data,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_err
);

  state_t                  state, state_next;
  logic [COUNT_WIDTH-1:0]  num_words;
  logic [BANK_WIDTH-1:0]   bank;
  logic [ADDR_WIDTH-1:0]   addr;
  logic                    accept, pack_clear, word_full_c;
  logic [KERNEL_WIDTH-1:0] word_c;
  logic                    start_ok, start_bad, last_write;

  assign accept     = i_byte_valid && o_byte_ready;
  assign start_ok   = (state == ST_IDLE) && i_start && count_legal(i_num_words);
  assign start_bad  = (state == ST_IDLE) && i_start && !count_legal(i_num_words);
  assign pack_clear = start_ok || (state == ST_WRITE);
  assign last_write = (bank == BANK_WIDTH'(NUM_BANKS - 1)) &&
                      ({1'b0, addr} == (num_words - COUNT_WIDTH'(1)));

  weight_byte_packer u_packer (
    .clk         (clk),
    .rst         (rst),
    .accept      (accept),
    .clear       (pack_clear),
    .byte_in     (i_byte),
    .word_full_c (word_full_c),
    .word_c      (word_c)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Next-state logic; abort takes priority over any pending transition.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (start_ok) state_next = ST_RECV;
      ST_RECV: begin
        if (i_abort)          state_next = ST_IDLE;
        else if (word_full_c) state_next = ST_WRITE;
      end
      ST_WRITE: begin
        if (i_abort)          state_next = ST_IDLE;
        else if (last_write)  state_next = ST_DONE;
        else                  state_next = ST_RECV;
      end
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Registered outputs follow the state being entered; counters advance in WRITE.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_byte_ready <= 1'b0;
      o_wr_en      <= '0;
      o_wr_addr    <= '0;
      o_wr_data    <= '0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      o_err        <= 1'b0;
      num_words    <= '0;
      bank         <= '0;
      addr         <= '0;
    end else begin
      o_byte_ready <= (state_next == ST_RECV);
      o_busy       <= (state_next == ST_RECV) || (state_next == ST_WRITE);
      o_done       <= (state_next == ST_DONE);
      o_err        <= start_bad;
      o_wr_en      <= '0;
      if (start_ok) begin
        num_words <= i_num_words;
        bank      <= '0;
        addr      <= '0;
      end
      if ((state == ST_RECV) && (state_next == ST_WRITE)) begin
        o_wr_en   <= bank_onehot(bank);
        o_wr_addr <= addr;
        o_wr_data <= word_c;
      end
      if (state == ST_WRITE) begin
        bank <= bank + 1'b1;
        if (bank == BANK_WIDTH'(NUM_BANKS - 1)) addr <= addr + 1'b1;
      end
    end
  end

endmodule

// File: doc/weight_wr_ctrl.md
Name: weight_wr_ctrl

Overview:
- Writer side of the 72-bit weight-ROM/RAM interface.
- Takes a byte stream from the host/DMA and packs 9 bytes into one 72-bit kernel word (9 x 8-bit weights).
- Writes words round-robin across NUM_BANKS weight banks at a shared address, matching the layout the weight loader reads back: same address across all banks.
- Signals completion so the downstream loader can start.

Parameters:
- KERNEL_WIDTH, 72: bits per kernel word (9 weights x 8 bits).
- NUM_BANKS, 4: number of weight banks written round-robin.
- ADDR_WIDTH, 10: bank address width (1024 words per bank).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- i_start  in  1  one-cycle start pulse; sampled only in IDLE.
- i_num_words  in  ADDR_WIDTH+1  words per bank for this load; legal range 1..2^ADDR_WIDTH; sampled with i_start.
- i_abort  in  1  abandons the load; the current partial word is discarded.
- i_byte_valid  in  1  byte-stream valid.
- i_byte  in  8  byte-stream data.
- o_byte_ready  out  1  byte-stream ready.
- o_wr_en  out  NUM_BANKS  one-hot bank write strobe.
- o_wr_addr  out  ADDR_WIDTH  bank write address.
- o_wr_data  out  KERNEL_WIDTH  packed kernel word.
- o_busy  out  1  high from start acceptance until done/abort/error.
- o_done  out  1  one-cycle pulse after the final write.
- o_err  out  1  one-cycle pulse on a start with illegal i_num_words.

Behaviour:
- Reset: every output is 0, FSM goes to IDLE, and all counters clear. Reset mid-load discards the partial word and issues no write.
- FSM states: IDLE, RECV, WRITE, DONE.
- IDLE:
  - i_start with legal i_num_words: latch the count, clear byte_cnt/bank/addr, go to RECV next cycle with o_busy=1.
  - i_start with i_num_words==0 or >2^ADDR_WIDTH: o_err=1 the next cycle; stay in IDLE, o_busy stays 0.
- RECV:
  - o_byte_ready=1.
  - A byte is accepted when i_byte_valid && o_byte_ready.
  - Byte k (0..8) of a word lands in bits [8k+7:8k], so the first byte is weight 0 in the LSBs.
  - byte_cnt increments per accepted byte. Acceptance of the 9th byte goes to WRITE; valid gaps simply stall.
- WRITE (exactly 1 cycle):
  - o_byte_ready=0.
  - o_wr_en=(1<<bank), o_wr_addr=addr, o_wr_data=packed word.
  - Latency: o_wr_en is high in the cycle after the 9th byte is accepted.
  - Afterwards bank increments. When bank wraps NUM_BANKS-1 -> 0, addr increments.
  - If bank==NUM_BANKS-1 and addr==num_words-1, go to DONE; otherwise go to RECV.
- DONE: o_done=1 for one cycle, o_busy drops in the same cycle, next state IDLE.
- Outside WRITE, o_wr_en=0 and o_wr_addr/o_wr_data hold their last values.
- i_start in any state other than IDLE is ignored.
- i_abort in RECV/WRITE/DONE:
  - Next state IDLE, o_busy=0 next cycle, no o_done.
  - Abort wins over a simultaneous WRITE; the write still occurs in that cycle, since the strobe is already registered.
  - No further writes after the abort.
- Total stream length: 9 x NUM_BANKS x num_words bytes. Throughput: 9 bytes per 10 cycles.
- Bytes offered while o_byte_ready=0 are not consumed.

Decomposition:
- Shared package holds:
  - KERNEL_WIDTH, NUM_BANKS, ADDR_WIDTH.
  - BYTES_PER_WORD=9.
  - The FSM state encoding.
  - The bank one-hot helper.
- One natural sub-module, weight_byte_packer:
  - 9-byte shift/insert register with a 4-bit byte counter.
  - Inputs: accept and clear. Outputs: word_full and word.
- The FSM, bank/addr counters and write port live in weight_wr_ctrl.

Test Plan:
- Basic load:
  - Stimulus: num_words=1, continuous valid, bytes 0x01..0x24.
  - Required: 4 writes with o_wr_en=0001,0010,0100,1000, all at addr 0.
  - Required: bank0 data=0x090807060504030201 and bank3 data=0x24232221201F1E1D1C.
  - Required: o_done pulses in the cycle after the 4th write.
- Multi-address load:
  - Stimulus: num_words=2, 72 bytes.
  - Required: 8 writes; addr=0 for the first 4 and addr=1 for the last 4; exactly one o_done; o_busy low afterwards.
- Valid gaps:
  - Stimulus: i_byte_valid drops for 3 cycles after byte 4 of word 0.
  - Required: identical write data; the first write is delayed 3 cycles; no extra bytes consumed.
- Illegal count:
  - Stimulus: i_num_words=0 and, separately, 1025.
  - Required: o_err pulses 1 cycle; o_busy, o_byte_ready and o_wr_en stay 0.
- Abort and start-while-busy:
  - Stimulus: i_abort after 5 bytes.
  - Required: no write; o_busy=0 next cycle.
  - Stimulus: a new start with num_words=1.
  - Required: the first write goes to bank0, addr0, with fresh data.
  - Stimulus: i_start pulsed mid-load.
  - Required: ignored.
- Reset mid-load:
  - Stimulus: rst asserted during byte 7 of word 2.
  - Required: all outputs 0 the next cycle; a subsequent full load completes correctly.
